label_demux: RTL and testbench
==============================

LABEL_DEMUX -- requirements
Module: label_demux

Interface
- REQ-001: Parameter DW, default 8, data width in bits of every data port.
- REQ-002: Parameter DEPTH, default 4, entries per domain queue; power of two, at least 2.
- REQ-003: clk  input  1  clock; all state updates on the rising edge.
- REQ-004: rst  input  1  reset; synchronous, active-high.
- REQ-005: in_valid  input  1  producer offers a labelled word this cycle.
- REQ-006: in_lbl  input  1  security label of the offered word: 0 = L domain, 1 = H domain.
- REQ-007: in_data  input  DW  offered word; its confidentiality is given by in_lbl.
- REQ-008: in_ready  output  1  this block accepts the offered word this cycle.
- REQ-009: lo_valid  output  1  L-domain queue head is valid.
- REQ-010: lo_data  output  DW  L-domain queue head.
- REQ-011: lo_ready  input  1  L-domain consumer takes the head this cycle.
- REQ-012: hi_valid  output  1  H-domain queue head is valid.
- REQ-013: hi_data  output  DW  H-domain queue head.
- REQ-014: hi_ready  input  1  H-domain consumer takes the head this cycle.

Function
- REQ-015: The block SHALL hold two independent FIFOs, Q_L and Q_H, each DEPTH x DW, with a write pointer, read pointer and occupancy counter (0..DEPTH).
- REQ-016: in_ready SHALL be combinational: !full(Q_L) when in_lbl=0, !full(Q_H) when in_lbl=1.
- REQ-017: A push SHALL occur iff in_valid && in_ready; the word goes to Q_L if in_lbl=0, else Q_H; no word is ever written to the other queue.
- REQ-018: lo_valid SHALL equal (count_L != 0); hi_valid SHALL equal (count_H != 0).
- REQ-019: A pop of Q_L SHALL occur iff lo_valid && lo_ready; a pop of Q_H iff hi_valid && hi_ready.
- REQ-020: lo_data SHALL be the Q_L head when lo_valid=1 and all-zero otherwise; hi_data likewise for Q_H. No output ever exposes a stale or other-domain entry.
- REQ-021: Latency: a word pushed at edge N SHALL appear at the queue head (valid high) in the cycle after edge N when the queue was empty; no combinational input-to-output bypass.
- REQ-022: Order SHALL be preserved within each domain; no ordering relation between domains.
- REQ-023: Pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH nor underflow.
- REQ-024: Simultaneous push and pop on the same queue SHALL leave its count unchanged and be legal even when full (pop frees the slot only on the next cycle; in_ready stays 0 while full).
- REQ-025: Simultaneous push to one queue and pop from the other SHALL update both counts independently in the same cycle.
- REQ-026: Q_H occupancy, hi_ready and H data SHALL never influence lo_valid, lo_data or Q_L state; Q_L state MAY influence H-side signals.
- REQ-027: On pop, the vacated storage entry SHALL be cleared to zero in the same edge.

Reset
- REQ-028: While rst=1 at an edge: both counts, all pointers and all storage entries SHALL become 0; pushes and pops that cycle are discarded.
- REQ-029: After reset: lo_valid=0, hi_valid=0, lo_data=0, hi_data=0, in_ready=1 for either label.
- REQ-030: Reset asserted mid-operation SHALL drop all queued words of both domains; no word is delivered after reset deassertion unless pushed anew.

Verification
- REQ-031: Push (lbl=0, 0x11), (lbl=1, 0x22), (lbl=0, 0x33), both ready=1 -> lo sees 0x11 then 0x33, hi sees 0x22, one cycle after each push; lo never shows 0x22.
- REQ-032: hi_ready=0, push 4 words lbl=1 -> hi count 4, in_ready=0 for lbl=1 yet 1 for lbl=0; a lbl=0 word 0x5A is accepted and appears on lo next cycle.
- REQ-033: Q_L full (0xA0..0xA3), lo_ready=1 and push 0xA4 lbl=0 same cycle -> push refused (in_ready=0), 0xA0 popped; next cycle in_ready=1, 0xA4 accepted, output order A1,A2,A3,A4.
- REQ-034: 10 push/pop cycles on Q_H at DEPTH=4 -> pointer wrap; output sequence equals input sequence, count stays 1.
- REQ-035: Three words queued per domain, rst=1 for one cycle -> both valids 0, data outputs 0, in_ready=1; no old word reappears.
- REQ-036: Randomised H-side traffic with identical L-side stimulus -> lo_valid/lo_data traces are bit-identical across runs.

Source files
------------

// File: rtl/label_demux.sv
// Label-steered demultiplexer: one labelled input stream split into two
// isolated FIFOs, one per security domain (L and H).

module label_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop_ready,
  output logic          full,
  output logic          head_valid,
  output logic [DW-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop;

  assign full       = (count == FULL_COUNT);
  assign head_valid = (count != '0);
  assign pop        = head_valid && pop_ready;
  // The head is masked so an empty queue never exposes a leftover entry.
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // A vacated slot is zeroed before any write so both can share one edge;
  // while not full the write slot never coincides with the read slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) begin
        mem[rd_ptr] <= '0;
        rd_ptr      <= rd_ptr + AW'(1);
      end
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

module label_demux #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_lbl,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          lo_valid,
  output logic [DW-1:0] lo_data,
  input  logic          lo_ready,
  output logic          hi_valid,
  output logic [DW-1:0] hi_data,
  input  logic          hi_ready
);

  logic full_l;
  logic full_h;
  logic push_l;
  logic push_h;

  // The L queue only ever sees L-labelled traffic and its own fullness, so
  // nothing on the H side can reach lo_valid/lo_data.
  assign in_ready = in_lbl ? !full_h : !full_l;
  assign push_l   = in_valid && !in_lbl && !full_l;
  assign push_h   = in_valid &&  in_lbl && !full_h;

  label_fifo #(.DW(DW), .DEPTH(DEPTH)) u_q_l (
    .clk        (clk),
    .rst        (rst),
    .push       (push_l),
    .push_data  (in_data),
    .pop_ready  (lo_ready),
    .full       (full_l),
    .head_valid (lo_valid),
    .head_data  (lo_data)
  );

  label_fifo #(.DW(DW), .DEPTH(DEPTH)) u_q_h (
    .clk        (clk),
    .rst        (rst),
    .push       (push_h),
    .push_data  (in_data),
    .pop_ready  (hi_ready),
    .full       (full_h),
    .head_valid (hi_valid),
    .head_data  (hi_data)
  );

endmodule

// File: tb/tb_label_demux.sv
// Scoreboard bench for label_demux: a negedge monitor models both domain
// queues while scenario tasks drive traffic and check specific outcomes.

module tb_label_demux;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_lbl = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          lo_valid;
  logic [DW-1:0] lo_data;
  logic          lo_ready = 1'b0;
  logic          hi_valid;
  logic [DW-1:0] hi_data;
  logic          hi_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_lo[$];
  logic [DW-1:0] exp_hi[$];
  logic [DW:0]   lo_trace[32];

  label_demux #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_lbl   (in_lbl),
    .in_data  (in_data),
    .in_ready (in_ready),
    .lo_valid (lo_valid),
    .lo_data  (lo_data),
    .lo_ready (lo_ready),
    .hi_valid (hi_valid),
    .hi_data  (hi_data),
    .hi_ready (hi_ready)
  );

  always #5 clk = ~clk;

  // Model both queues from stimulus alone and compare every cycle.
  always @(negedge clk) begin
    logic          exp_rdy;
    logic [DW-1:0] exp_d;
    if (rst) begin
      exp_lo.delete();
      exp_hi.delete();
    end else begin
      vectors++;
      if (lo_valid !== (exp_lo.size() != 0)) begin
        miscompares++;
        $display("[TB] FAIL mon_lo_valid t=%0t got %b want %b", $time, lo_valid, exp_lo.size() != 0);
      end
      exp_d = (exp_lo.size() != 0) ? exp_lo[0] : '0;
      vectors++;
      if (lo_data !== exp_d) begin
        miscompares++;
        $display("[TB] FAIL mon_lo_data t=%0t got %h want %h", $time, lo_data, exp_d);
      end
      vectors++;
      if (hi_valid !== (exp_hi.size() != 0)) begin
        miscompares++;
        $display("[TB] FAIL mon_hi_valid t=%0t got %b want %b", $time, hi_valid, exp_hi.size() != 0);
      end
      exp_d = (exp_hi.size() != 0) ? exp_hi[0] : '0;
      vectors++;
      if (hi_data !== exp_d) begin
        miscompares++;
        $display("[TB] FAIL mon_hi_data t=%0t got %h want %h", $time, hi_data, exp_d);
      end
      exp_rdy = in_lbl ? (exp_hi.size() < DEPTH) : (exp_lo.size() < DEPTH);
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("[TB] FAIL mon_in_ready t=%0t got %b want %b", $time, in_ready, exp_rdy);
      end
      if (exp_lo.size() != 0 && lo_ready) void'(exp_lo.pop_front());
      if (exp_hi.size() != 0 && hi_ready) void'(exp_hi.pop_front());
      if (in_valid && exp_rdy) begin
        if (in_lbl) exp_hi.push_back(in_data);
        else        exp_lo.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic lbl, input logic [DW-1:0] d);
    in_valid = v;
    in_lbl   = lbl;
    in_data  = d;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0);
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    #1;
    vectors++;
    if (lo_valid !== 1'b0 || hi_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_valids got lo=%b hi=%b want 0 0", lo_valid, hi_valid);
    end
    vectors++;
    if (lo_data !== '0 || hi_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got lo=%h hi=%h want 00 00", lo_data, hi_data);
    end
    for (int l = 0; l < 2; l++) begin
      in_lbl = l[0];
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL reset_in_ready lbl=%0d got %b want 1", l, in_ready);
      end
    end
    in_lbl = 1'b0;
    step();
  endtask

  task automatic test_basic_routing();
    logic [DW-1:0] d[3] = '{8'h11, 8'h22, 8'h33};
    logic          l[3] = '{1'b0, 1'b1, 1'b0};
    lo_ready = 1'b1;
    hi_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, l[i], d[i]);
      step();
      vectors++;
      if ((l[i] ? {hi_valid, hi_data} : {lo_valid, lo_data}) !== {1'b1, d[i]}) begin
        miscompares++;
        $display("[TB] FAIL basic_next_cycle word=%h got lo=%b/%h hi=%b/%h", d[i], lo_valid, lo_data, hi_valid, hi_data);
      end
      vectors++;
      if (lo_data === 8'h22) begin
        miscompares++;
        $display("[TB] FAIL basic_lo_leak got %h want not 22", lo_data);
      end
    end
    drive(1'b0, 1'b0, '0);
    repeat (3) step();
  endtask

  task automatic test_hi_full();
    lo_ready = 1'b0;
    hi_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 8'hC0 + 8'(i));
      step();
    end
    in_lbl = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hifull_ready_h got %b want 0", in_ready);
    end
    drive(1'b1, 1'b0, 8'h5A);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hifull_ready_l got %b want 1", in_ready);
    end
    step();
    drive(1'b0, 1'b0, '0);
    vectors++;
    if (lo_valid !== 1'b1 || lo_data !== 8'h5A) begin
      miscompares++;
      $display("[TB] FAIL hifull_lo_word got %b/%h want 1/5a", lo_valid, lo_data);
    end
    lo_ready = 1'b1;
    hi_ready = 1'b1;
    repeat (DEPTH + 2) step();
  endtask

  task automatic test_lo_full_pop();
    lo_ready = 1'b0;
    hi_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 8'hA0 + 8'(i));
      step();
    end
    lo_ready = 1'b1;
    drive(1'b1, 1'b0, 8'hA4);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lofull_refuse got %b want 0", in_ready);
    end
    step();
    vectors++;
    if (in_ready !== 1'b1 || lo_data !== 8'hA1) begin
      miscompares++;
      $display("[TB] FAIL lofull_after_pop got rdy=%b head=%h want 1/a1", in_ready, lo_data);
    end
    step();
    drive(1'b0, 1'b0, '0);
    repeat (DEPTH + 2) step();
  endtask

  task automatic test_back_to_back_wrap();
    lo_ready = 1'b0;
    hi_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 8'h30 + 8'(i));
      step();
      vectors++;
      if (hi_valid !== 1'b1 || hi_data !== 8'h30 + 8'(i)) begin
        miscompares++;
        $display("[TB] FAIL wrap_head i=%0d got %b/%h want 1/%h", i, hi_valid, hi_data, 8'h30 + 8'(i));
      end
    end
    drive(1'b0, 1'b0, '0);
    repeat (2) step();
  endtask

  task automatic test_mid_reset();
    lo_ready = 1'b0;
    hi_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i[0], 8'hE0 + 8'(i));
      step();
    end
    do_reset(1);
    #1;
    vectors++;
    if ({lo_valid, hi_valid, lo_data, hi_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs got %b %b %h %h want all 0", lo_valid, hi_valid, lo_data, hi_data);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_in_ready got %b want 1", in_ready);
    end
    lo_ready = 1'b1;
    hi_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_isolation();
    for (int run = 0; run < 2; run++) begin
      do_reset(1);
      for (int i = 0; i < 32; i++) begin
        lo_ready = (i % 3) != 0;
        hi_ready = 1'($urandom_range(0, 1));
        if (i[0] == 1'b0) drive(1'b1, 1'b0, 8'h40 + 8'(i));
        else              drive(1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
        step();
        if (run == 0) begin
          lo_trace[i] = {lo_valid, lo_data};
        end else begin
          vectors++;
          if ({lo_valid, lo_data} !== lo_trace[i]) begin
            miscompares++;
            $display("[TB] FAIL isolation_trace i=%0d got %h want %h", i, {lo_valid, lo_data}, lo_trace[i]);
          end
        end
      end
    end
    drive(1'b0, 1'b0, '0);
    lo_ready = 1'b1;
    hi_ready = 1'b1;
    repeat (DEPTH + 2) step();
  endtask

  initial begin
    test_reset();
    test_basic_routing();
    test_hi_full();
    test_lo_full_pop();
    test_back_to_back_wrap();
    test_mid_reset();
    test_isolation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
